de_input_conditioner: RTL and testbench
=======================================

// Module: de_input_conditioner
// PURPOSE
//  Front-end stage between the DE-series board pins (SW, KEY) and the lab logic.
//  Synchronises every switch and pushbutton to CLOCK_50, then debounces each bit.
//  Converts the active-low KEY pins to active-high levels.
//  Emits one-cycle press/release pulses so downstream counters and FSMs see clean events.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  stable cycles required before a level is accepted (20 ms @ 50 MHz); min 1
//  REPEAT_DELAY     25000000 cycles from press pulse to first auto-repeat pulse (used only with macro)
//  REPEAT_PERIOD    5000000  cycles between subsequent auto-repeat pulses (used only with macro)
// PORTS
//  CLOCK_50     in   1   50 MHz clock; all state on rising edge
//  reset        in   1   synchronous, active-high reset
//  SW           in   10  raw switch pins, asynchronous
//  KEY          in   4   raw pushbutton pins, asynchronous, active-low (0 = pressed)
//  sw_clean     out  10  debounced switch levels
//  key_clean    out  4   debounced key levels, active-high (1 = pressed)
//  key_press    out  4   one-cycle pulse per accepted press (plus repeats, see CONFIGURATION)
//  key_release  out  4   one-cycle pulse per accepted release
// BEHAVIOUR
//  - Sync: 2-FF chain per bit. KEY is inverted before the chain.
//    Sync reset value is 0 for all bits, i.e. released/off.
//  - Debounce, per bit, fully independent: a counter of width $clog2(DEBOUNCE_CYCLES+1).
//    If sync_out == clean: counter <= 0.
//    If sync_out != clean and counter == DEBOUNCE_CYCLES-1: clean <= sync_out, counter <= 0.
//    Otherwise: counter <= counter + 1.
//    Any bounce back to the clean level restarts the count from 0.
//  - Latency: a pin change held steady appears on *_clean exactly 2+DEBOUNCE_CYCLES rising edges later.
//  - key_press[i] is high in exactly the cycle in which key_clean[i] first reads 1.
//    key_release[i] is high in exactly the cycle in which key_clean[i] first reads 0.
//    Both are registered and never high together.
//  - No pulses on switches; sw_clean is a level only.
//  - Reset, including mid-debounce: all outputs 0, all counters 0, sync chains 0.
//    No press or release pulse is generated by reset or by its deassertion.
//    A pin already active at reset release is accepted after the normal 2+DEBOUNCE_CYCLES.
//  - Simultaneous changes on multiple bits are accepted on the same cycle. Pulses coincide.
//  - Counters saturate by construction; no wrap-around is possible.
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined:
//    - While key_clean[i] stays 1, a per-key repeat counter generates additional key_press[i] pulses.
//    - The first repeat pulse occurs REPEAT_DELAY cycles after the press pulse.
//    - Each further pulse occurs every REPEAT_PERIOD cycles.
//    - Release or reset clears the repeat counter immediately. No repeat pulse occurs in the release cycle.
//  KEY_AUTOREPEAT_EN undefined:
//    - No repeat logic is synthesised. REPEAT_* are ignored.
//    - Exactly one key_press pulse per accepted press.
// TESTING (bench uses DEBOUNCE_CYCLES=4; edges are counted from the first edge that samples the new pin value)
//  1. Reset, then SW 0x000->0x2A5 and hold -> sw_clean stays 0x000 for 5 edges, reads 0x2A5 after edge 6.
//     key_press and key_release stay 0 throughout.
//  2. KEY[0] bounce low3/high1/low-held -> key_clean[0] stays 0 through the bounce.
//     key_clean[0] reads 1 six edges after the final transition; key_press[0] is high for one cycle only.
//  3. Release KEY[0] (pin high) and hold -> key_release[0] pulses once, six edges later.
//     key_clean[0] reads 0; key_press stays 0.
//  4. KEY[1] low for 3 cycles, then reset for 1 cycle, KEY[1] held low -> all outputs 0 during reset.
//     key_press[1] appears six edges after reset deasserts, not earlier.
//  5. KEY[3:0] all driven low on the same edge -> key_press==4'hF for exactly one cycle.
//     key_clean==4'hF afterwards.
//  6. With KEY_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, KEY[2] held -> key_press[2] pulses at t, t+10, t+15, t+20.
//     Without the macro, only the pulse at t.

Source files
------------

// File: rtl/de_input_conditioner.sv
// de_input_conditioner: synchronise, debounce and edge-detect DE-board SW/KEY pins (optional KEY_AUTOREPEAT_EN)
module de_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [9:0] sw_clean,
  output logic [3:0] key_clean,
  output logic [3:0] key_press,
  output logic [3:0] key_release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("de_input_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end
  logic [13:0] s1_q, s2_q, clean_q, clean_d;
  logic [CW-1:0] cnt_q [14];
  logic [CW-1:0] cnt_d [14];
  logic [3:0] press_q, press_d, release_q, release_d, rep_fire;
  // Debounce: accept a level only after it has differed from clean for DEBOUNCE_CYCLES edges in a row
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < 14; i++) begin
      cnt_d[i] = (s2_q[i] == clean_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
      clean_d[i] = (s2_q[i] != clean_q[i] && cnt_q[i] == LAST) ? s2_q[i] : clean_q[i];
    end
    press_d = (clean_d[13:10] & ~clean_q[13:10]) | rep_fire;
    release_d = ~clean_d[13:10] & clean_q[13:10];
  end
  // Sync chains (KEY inverted to active-high first), debounce state and registered pulses
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      clean_q <= '0;
      press_q <= '0;
      release_q <= '0;
      for (int i = 0; i < 14; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= {~KEY, SW};
      s2_q <= s1_q;
      clean_q <= clean_d;
      press_q <= press_d;
      release_q <= release_d;
      for (int i = 0; i < 14; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  localparam logic [RW-1:0] RD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP = RW'(REPEAT_PERIOD - 1);
  logic [RW-1:0] rcnt_q [4];
  logic [RW-1:0] rcnt_d [4];
  logic [3:0] first_q, first_d;
  // Repeat timer runs only while a key stays pressed across the edge; first interval is the longer delay
  always_comb begin
    first_d = first_q;
    rep_fire = '0;
    for (int i = 0; i < 4; i++) begin
      rep_fire[i] = clean_q[10+i] && clean_d[10+i] && rcnt_q[i] == (first_q[i] ? RD : RP);
      rcnt_d[i] = (!(clean_q[10+i] && clean_d[10+i]) || rep_fire[i]) ? '0 : rcnt_q[i] + 1'b1;
      first_d[i] = !(clean_q[10+i] && clean_d[10+i]) || (first_q[i] && !rep_fire[i]);
    end
  end
  // Repeat timer state
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      first_q <= '1;
      for (int i = 0; i < 4; i++) rcnt_q[i] <= '0;
    end else begin
      first_q <= first_d;
      for (int i = 0; i < 4; i++) rcnt_q[i] <= rcnt_d[i];
    end
  end
`else
  assign rep_fire = '0;
`endif
  assign sw_clean = clean_q[9:0];
  assign key_clean = clean_q[13:10];
  assign key_press = press_q;
  assign key_release = release_q;
endmodule

// File: tb/tb_de_input_conditioner.sv
// tb_de_input_conditioner: directed vector table plus auto-repeat sequence for de_input_conditioner
module tb_de_input_conditioner;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] sw;
  logic [3:0] key;
  logic [9:0] sw_clean;
  logic [3:0] key_clean, key_press, key_release;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic rst;
    logic [9:0] sw;
    logic [3:0] key;
    logic [9:0] esw;
    logic [3:0] ekc;
    logic [3:0] ekp;
    logic [3:0] ekr;
  } vec_t;
  vec_t vq[$];
  always #5 clk = ~clk;
  de_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .SW(sw),
    .KEY(key),
    .sw_clean(sw_clean),
    .key_clean(key_clean),
    .key_press(key_press),
    .key_release(key_release)
  );
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic add(input int n, input logic r, input logic [9:0] s, input logic [3:0] k,
                     input logic [9:0] es, input logic [3:0] ekc, input logic [3:0] ekp, input logic [3:0] ekr);
    vec_t v;
    v.rst = r; v.sw = s; v.key = k; v.esw = es; v.ekc = ekc; v.ekp = ekp; v.ekr = ekr;
    repeat (n) vq.push_back(v);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit found;
    logic [3:0] exp_p;
    rst = 1'b1; sw = '0; key = 4'hF;
    // 1: reset, then switches latch 6 edges after change
    add(2, 1, 10'h000, 4'hF, 10'h000, 4'h0, 4'h0, 4'h0);
    add(5, 0, 10'h2A5, 4'hF, 10'h000, 4'h0, 4'h0, 4'h0);
    add(2, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0, 4'h0);
    // 2: KEY[0] bounce low3/high1/low held
    add(3, 0, 10'h2A5, 4'hE, 10'h2A5, 4'h0, 4'h0, 4'h0);
    add(1, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0, 4'h0);
    add(5, 0, 10'h2A5, 4'hE, 10'h2A5, 4'h0, 4'h0, 4'h0);
    add(1, 0, 10'h2A5, 4'hE, 10'h2A5, 4'h1, 4'h1, 4'h0);
    add(1, 0, 10'h2A5, 4'hE, 10'h2A5, 4'h1, 4'h0, 4'h0);
    // 3: release KEY[0]
    add(5, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h1, 4'h0, 4'h0);
    add(1, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0, 4'h1);
    add(1, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0, 4'h0);
    // 4: KEY[1] low, reset mid-debounce, held low
    add(3, 0, 10'h2A5, 4'hD, 10'h2A5, 4'h0, 4'h0, 4'h0);
    add(1, 1, 10'h2A5, 4'hD, 10'h000, 4'h0, 4'h0, 4'h0);
    add(5, 0, 10'h2A5, 4'hD, 10'h000, 4'h0, 4'h0, 4'h0);
    add(1, 0, 10'h2A5, 4'hD, 10'h2A5, 4'h2, 4'h2, 4'h0);
    add(1, 0, 10'h2A5, 4'hD, 10'h2A5, 4'h2, 4'h0, 4'h0);
    // 5: release, then all keys pressed together
    add(5, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h2, 4'h0, 4'h0);
    add(1, 0, 10'h2A5, 4'hF, 10'h2A5, 4'h0, 4'h0, 4'h2);
    add(5, 0, 10'h2A5, 4'h0, 10'h2A5, 4'h0, 4'h0, 4'h0);
    add(1, 0, 10'h2A5, 4'h0, 10'h2A5, 4'hF, 4'hF, 4'h0);
    add(1, 0, 10'h2A5, 4'h0, 10'h2A5, 4'hF, 4'h0, 4'h0);
    foreach (vq[i]) begin
      rst = vq[i].rst; sw = vq[i].sw; key = vq[i].key;
      step;
      check("sw_clean", i, 32'(sw_clean), 32'(vq[i].esw));
      check("key_clean", i, 32'(key_clean), 32'(vq[i].ekc));
      check("key_press", i, 32'(key_press), 32'(vq[i].ekp));
      check("key_release", i, 32'(key_release), 32'(vq[i].ekr));
    end
    // 6: KEY[2] held, auto-repeat timing (or single pulse without it)
    rst = 1'b1; key = 4'hF;
    step;
    rst = 1'b0; key = 4'hB;
    found = 1'b0;
    for (int e = 1; e <= 12 && !found; e++) begin
      step;
      if (key_press[2]) begin
        found = 1'b1;
        check("t6_first_press_edge", e, 32'(e), 32'd6);
      end
    end
    if (!found) check("t6_press_timeout", 0, 32'd0, 32'd1);
    for (int k = 1; k <= 22; k++) begin
      step;
`ifdef KEY_AUTOREPEAT_EN
      exp_p = (k == 10 || k == 15 || k == 20) ? 4'h4 : 4'h0;
`else
      exp_p = 4'h0;
`endif
      check("t6_repeat", k, 32'(key_press), 32'(exp_p));
      check("t6_held", k, 32'(key_clean), 32'h4);
    end
    key = 4'hF;
    repeat (6) step;
    check("t6_release", 0, 32'(key_release), 32'h4);
    check("t6_release_press", 0, 32'(key_press), 32'h0);
    check("t6_release_clean", 0, 32'(key_clean), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
